// File: rtl/lsf_mc_spy_fifo.sv
// lsf_mc_spy_fifo -- multi-channel LSF input buffer with spy ring.
//   NCH hit streams are each staged in a 2-entry FIFO. A round-robin arbiter
//   moves at most one staged word per cycle into a first-word-fall-through
//   main FIFO that holds {channel, data}. Every moved word is also mirrored
//   into a freezable spy ring, which can be read back one cycle after a read
//   strobe.
// Optional feature: define LSF_SPY_META_EN to build the event-metadata ring.
//   The metadata ring records the spy write address at each i_eof strobe.
// Ports:
//   clock, resetbar           clock, async active-low reset
//   in_data/in_we             per-channel write data and strobe
//   in_af/ovf                 registered almost-full, sticky drop flag
//   out_data/out_ch/out_empty main FIFO head word, its channel, empty flag
//   out_re                    pop the head word
//   i_eof                     event boundary strobe (metadata only)
//   sb_freeze                 inhibit spy and metadata capture
//   sb_re/sb_raddr/sb_rdata   spy ring read port (registered data)
//   sb_waddr/sb_wrapped       spy write pointer, sticky wrap flag
//   sb_meta_*                 metadata read port and saturating event count
`ifndef HEG2SFHIT_LEN
`define HEG2SFHIT_LEN 32
`endif

module lsf_mc_spy_fifo #(
  parameter int NCH             = 2,
  parameter int DATA_WIDTH      = `HEG2SFHIT_LEN,
  parameter int FIFO_DEPTH_LOG2 = 5,
  parameter int AF_MARGIN       = 4,
  parameter int SPY_DEPTH_LOG2  = 10,
  parameter int META_DEPTH_LOG2 = 6
) (
  input  logic                          clock,
  input  logic                          resetbar,
  input  logic [NCH*DATA_WIDTH-1:0]     in_data,
  input  logic [NCH-1:0]                in_we,
  output logic [NCH-1:0]                in_af,
  output logic [NCH-1:0]                ovf,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NCH)-1:0]        out_ch,
  output logic                          out_empty,
  input  logic                          out_re,
  input  logic                          i_eof,
  input  logic                          sb_freeze,
  input  logic                          sb_re,
  input  logic [SPY_DEPTH_LOG2-1:0]     sb_raddr,
  output logic [DATA_WIDTH-1:0]         sb_rdata,
  output logic [SPY_DEPTH_LOG2-1:0]     sb_waddr,
  output logic                          sb_wrapped,
  input  logic                          sb_meta_re,
  input  logic [META_DEPTH_LOG2-1:0]    sb_meta_raddr,
  output logic [SPY_DEPTH_LOG2-1:0]     sb_meta_rdata,
  output logic [META_DEPTH_LOG2:0]      sb_meta_count
);
  localparam int CW    = $clog2(NCH);
  localparam int FL    = FIFO_DEPTH_LOG2;
  localparam int SL    = SPY_DEPTH_LOG2;
  localparam int ML    = META_DEPTH_LOG2;
  localparam int DEPTH = 1 << FL;
  localparam logic [FL:0] MFULL = (FL+1)'(DEPTH);
  localparam logic [FL:0] AF_TH = (FL+1)'(DEPTH - AF_MARGIN);

  logic [NCH-1:0]                 stg_ne;
  logic [NCH-1:0][DATA_WIDTH-1:0] stg_head;
  logic                           gnt_vld;
  logic [CW-1:0]                  gnt_ch, rr_q, rr_d;
  logic [CW:0]                    arb_idx;
  logic [FL:0]                    mcnt_q;
  logic [FL-1:0]                  mwp_q, mrp_q;
  logic                           m_full, m_pop;

  assign m_full = (mcnt_q == MFULL);
  assign m_pop  = out_re && (mcnt_q != '0);

  // Per-channel 2-entry staging FIFO; the drop decision uses the registered
  // count, so a write to a full stage is lost even if it drains this cycle.
  for (genvar c = 0; c < NCH; c++) begin : g_stg
    logic [1:0][DATA_WIDTH-1:0] mem_q;
    logic                       wp_q, rp_q, ovf_q, af_q, push, pop;
    logic [1:0]                 cnt_q;

    assign push        = in_we[c] && (cnt_q != 2'd2);
    assign pop         = gnt_vld && (gnt_ch == CW'(c));
    assign stg_ne[c]   = (cnt_q != 2'd0);
    assign stg_head[c] = mem_q[rp_q];
    assign ovf[c]      = ovf_q;
    assign in_af[c]    = af_q;

    always_ff @(posedge clock)
      if (push) mem_q[wp_q] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clock or negedge resetbar) begin
      if (!resetbar) begin
        wp_q  <= 1'b0;
        rp_q  <= 1'b0;
        cnt_q <= 2'd0;
        ovf_q <= 1'b0;
        af_q  <= 1'b0;
      end else begin
        if (push) wp_q <= ~wp_q;
        if (pop)  rp_q <= ~rp_q;
        cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        if (in_we[c] && (cnt_q == 2'd2)) ovf_q <= 1'b1;
        af_q  <= stg_ne[c] || (mcnt_q >= AF_TH);
      end
    end
  end

  // Round-robin: first non-empty stage at or after rr, modulo NCH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    arb_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      arb_idx = {1'b0, rr_q} + (CW+1)'(k);
      if (arb_idx >= (CW+1)'(NCH)) arb_idx = arb_idx - (CW+1)'(NCH);
      if (!gnt_vld && !m_full && stg_ne[arb_idx[CW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_ch  = arb_idx[CW-1:0];
      end
    end
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_ch == CW'(NCH-1)) ? '0 : gnt_ch + CW'(1);
  end

  // Main FWFT FIFO of {channel, data}.
  logic [CW+DATA_WIDTH-1:0] mmem [DEPTH];

  always_ff @(posedge clock)
    if (gnt_vld) mmem[mwp_q] <= {gnt_ch, stg_head[gnt_ch]};

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      mwp_q  <= '0;
      mrp_q  <= '0;
      mcnt_q <= '0;
      rr_q   <= '0;
    end else begin
      if (gnt_vld) mwp_q <= mwp_q + FL'(1);
      if (m_pop)   mrp_q <= mrp_q + FL'(1);
      mcnt_q <= mcnt_q + (FL+1)'(gnt_vld) - (FL+1)'(m_pop);
      rr_q   <= rr_d;
    end
  end

  assign {out_ch, out_data} = mmem[mrp_q];
  assign out_empty          = (mcnt_q == '0);

  // Spy ring: mirrors every granted word unless frozen. The read register
  // samples the RAM before this edge's write lands, so a same-address
  // read returns the old word.
  logic [DATA_WIDTH-1:0] spy_mem [1<<SL];
  logic [SL-1:0]         sb_waddr_q;
  logic                  sb_wrapped_q, spy_we;
  logic [DATA_WIDTH-1:0] sb_rdata_q;

  assign spy_we = gnt_vld && !sb_freeze;

  always_ff @(posedge clock)
    if (spy_we) spy_mem[sb_waddr_q] <= stg_head[gnt_ch];

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      sb_waddr_q   <= '0;
      sb_wrapped_q <= 1'b0;
      sb_rdata_q   <= '0;
    end else begin
      if (spy_we) begin
        sb_waddr_q <= sb_waddr_q + SL'(1);
        if (&sb_waddr_q) sb_wrapped_q <= 1'b1;
      end
      if (sb_re) sb_rdata_q <= spy_mem[sb_raddr];
    end
  end

  assign sb_waddr   = sb_waddr_q;
  assign sb_wrapped = sb_wrapped_q;
  assign sb_rdata   = sb_rdata_q;

`ifdef LSF_SPY_META_EN
  // Event metadata: spy write address at each unfrozen i_eof.
  localparam logic [ML:0] MSAT = (ML+1)'(1 << ML);
  logic [SL-1:0] meta_mem [1<<ML];
  logic [ML-1:0] meta_wp_q;
  logic [ML:0]   meta_cnt_q;
  logic [SL-1:0] meta_rdata_q;
  logic          meta_we;

  assign meta_we = i_eof && !sb_freeze;

  always_ff @(posedge clock)
    if (meta_we) meta_mem[meta_wp_q] <= sb_waddr_q;

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      meta_wp_q    <= '0;
      meta_cnt_q   <= '0;
      meta_rdata_q <= '0;
    end else begin
      if (meta_we) begin
        meta_wp_q <= meta_wp_q + ML'(1);
        if (meta_cnt_q != MSAT) meta_cnt_q <= meta_cnt_q + (ML+1)'(1);
      end
      if (sb_meta_re) meta_rdata_q <= meta_mem[sb_meta_raddr];
    end
  end

  assign sb_meta_rdata = meta_rdata_q;
  assign sb_meta_count = meta_cnt_q;
`else
  logic unused_meta;
  assign unused_meta   = ^{i_eof, sb_meta_re, sb_meta_raddr};
  assign sb_meta_rdata = '0;
  assign sb_meta_count = '0;
`endif

endmodule

// File: tb/tb_lsf_mc_spy_fifo.sv
// Randomized + directed bench for lsf_mc_spy_fifo against a queue-based
// reference model of staging, arbitration, main FIFO, spy and metadata rings.
module tb_lsf_mc_spy_fifo;
  localparam int NCH = 2, DW = 32, FL = 5, DEPTH = 32, AFM = 4;
  localparam int SL = 10, SPY = 1024, ML = 6, MD = 64;

  logic                clock, resetbar;
  logic [NCH*DW-1:0]   in_data;
  logic [NCH-1:0]      in_we, in_af, ovf;
  logic [DW-1:0]       out_data, sb_rdata;
  logic [0:0]          out_ch;
  logic                out_empty, out_re, i_eof, sb_freeze, sb_re, sb_wrapped, sb_meta_re;
  logic [SL-1:0]       sb_raddr, sb_waddr, sb_meta_rdata;
  logic [ML-1:0]       sb_meta_raddr;
  logic [ML:0]         sb_meta_count;

  lsf_mc_spy_fifo #(.NCH(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(FL), .AF_MARGIN(AFM),
                    .SPY_DEPTH_LOG2(SL), .META_DEPTH_LOG2(ML)) dut (
    .clock(clock), .resetbar(resetbar), .in_data(in_data), .in_we(in_we),
    .in_af(in_af), .ovf(ovf), .out_data(out_data), .out_ch(out_ch),
    .out_empty(out_empty), .out_re(out_re), .i_eof(i_eof), .sb_freeze(sb_freeze),
    .sb_re(sb_re), .sb_raddr(sb_raddr), .sb_rdata(sb_rdata), .sb_waddr(sb_waddr),
    .sb_wrapped(sb_wrapped), .sb_meta_re(sb_meta_re), .sb_meta_raddr(sb_meta_raddr),
    .sb_meta_rdata(sb_meta_rdata), .sb_meta_count(sb_meta_count));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic [DW-1:0] sdat [NCH][2];
  int            scnt [NCH];
  logic [DW-1:0] mq_d [$];
  int            mq_c [$];
  int            rr, m_waddr, m_mwp, m_mcnt;
  logic [NCH-1:0] m_af, m_ovf;
  bit            m_wrap;
  logic [DW-1:0] m_spy [SPY];
  bit            m_vld [SPY];
  logic [DW-1:0] m_rdata;
  logic [SL-1:0] m_meta [MD];
  logic [SL-1:0] m_mrdata;

  int errs = 0, checks = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) scnt[c] = 0;
    mq_d.delete(); mq_c.delete();
    rr = 0; m_waddr = 0; m_wrap = 0; m_mwp = 0; m_mcnt = 0;
    m_af = '0; m_ovf = '0; m_rdata = '0; m_mrdata = '0;
    for (int a = 0; a < SPY; a++) m_vld[a] = 0;
  endtask

  task automatic idle_in();
    in_we = '0; in_data = '0; out_re = 0; i_eof = 0; sb_freeze = 0;
    sb_re = 0; sb_raddr = '0; sb_meta_re = 0; sb_meta_raddr = '0;
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT sampled.
  task automatic model_edge();
    int g, c, pre [NCH];
    logic [DW-1:0] w;
    for (int i = 0; i < NCH; i++) begin
      pre[i]  = scnt[i];
      m_af[i] = (scnt[i] >= 1) || (mq_d.size() >= DEPTH - AFM);
    end
    if (sb_re) m_rdata = m_spy[sb_raddr];
`ifdef LSF_SPY_META_EN
    if (sb_meta_re) m_mrdata = m_meta[sb_meta_raddr];
    if (i_eof && !sb_freeze) begin
      m_meta[m_mwp] = SL'(m_waddr);
      m_mwp = (m_mwp + 1) % MD;
      if (m_mcnt < MD) m_mcnt++;
    end
`endif
    g = -1;
    if (mq_d.size() < DEPTH)
      for (int k = 0; k < NCH; k++) begin
        c = (rr + k) % NCH;
        if (g < 0 && scnt[c] > 0) g = c;
      end
    if (out_re && mq_d.size() > 0) begin
      void'(mq_d.pop_front()); void'(mq_c.pop_front());
    end
    if (g >= 0) begin
      w = sdat[g][0]; sdat[g][0] = sdat[g][1]; scnt[g]--;
      mq_d.push_back(w); mq_c.push_back(g);
      rr = (g + 1) % NCH;
      if (!sb_freeze) begin
        m_spy[m_waddr] = w; m_vld[m_waddr] = 1;
        m_waddr++;
        if (m_waddr == SPY) begin m_waddr = 0; m_wrap = 1; end
      end
    end
    for (int i = 0; i < NCH; i++)
      if (in_we[i]) begin
        if (pre[i] == 2) m_ovf[i] = 1'b1;
        else begin sdat[i][scnt[i]] = in_data[i*DW +: DW]; scnt[i]++; end
      end
  endtask

  task automatic compare();
    chk("out_empty", out_empty, mq_d.size() == 0);
    if (mq_d.size() > 0) begin
      chk("out_data", out_data, mq_d[0]);
      chk("out_ch", out_ch, mq_c[0]);
    end
    chk("in_af", in_af, m_af);
    chk("ovf", ovf, m_ovf);
    chk("sb_waddr", sb_waddr, m_waddr);
    chk("sb_wrapped", sb_wrapped, m_wrap);
    chk("sb_rdata", sb_rdata, m_rdata);
    chk("meta_rdata", sb_meta_rdata, m_mrdata);
    chk("meta_count", sb_meta_count, m_mcnt);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    #3 resetbar = 0;
    #1;
    chk("rst_empty", out_empty, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_af", in_af, 0);
    chk("rst_waddr", sb_waddr, 0);
    chk("rst_wrapped", sb_wrapped, 0);
    model_reset();
    idle_in();
    @(negedge clock);
    resetbar = 1;
  endtask

  // Push n words on ch0 one at a time (out_re as set by caller), then settle.
  task automatic push_n(int n, logic [DW-1:0] base);
    int sent = 0, guard = 0;
    while (sent < n && guard < 4*n + 20) begin
      if (scnt[0] == 0) begin
        in_we = 2'b01; in_data[DW-1:0] = base + DW'(sent); sent++;
      end else in_we = '0;
      step();
      guard++;
    end
    in_we = '0;
    repeat (4) step();
  endtask

  int n0;

  initial begin
    resetbar = 0;
    idle_in();
    model_reset();
    #22;
    compare();
    chk("init_sb_rdata", sb_rdata, 0);
    @(negedge clock);
    resetbar = 1;

    // single word on ch1, FIFO latency
    in_we = 2'b10; in_data[DW +: DW] = 32'hA5A5_0001;
    step();
    chk("e0_still_empty", out_empty, 1);
    in_we = '0;
    step();
    chk("e1_not_empty", out_empty, 0);
    chk("e1_ch", out_ch, 1);
    chk("e1_data", out_data, 32'hA5A5_0001);
    chk("e1_waddr", sb_waddr, 1);
    out_re = 1;
    step();

    // both channels, producers honour in_af
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < NCH; c++) begin
        in_we[c] = !in_af[c];
        in_data[c*DW +: DW] = $urandom;
      end
      step();
    end
    in_we = '0;
    repeat (10) step();
    chk("honour_no_ovf", ovf, 0);

    // fill main FIFO via ch1, then overrun ch0 staging
    out_re = 0;
    for (int i = 0; i < 200 && mq_d.size() < DEPTH; i++) begin
      in_we = {scnt[1] == 0, 1'b0};
      in_data[DW +: DW] = 32'hB000_0000 + i;
      step();
    end
    chk("main_full", out_empty, 0);
    for (int i = 0; i < 4; i++) begin
      in_we = 2'b01; in_data[DW-1:0] = 32'hC000_0000 + i;
      step();
    end
    in_we = '0;
    step();
    chk("ovf0_set", ovf[0], 1);
    chk("ovf1_clear", ovf[1], 0);
    out_re = 1;
    n0 = 0;
    for (int i = 0; i < 50; i++) begin
      if (!out_empty && out_ch == 0) n0++;
      step();
    end
    chk("stg_survivors", n0, 2);
    out_re = 0;
    push_n(3, 32'hD000_0000);
    do_reset();

    // 1030 words: spy ring wraps
    out_re = 1;
    push_n(1030, 0);
    chk("wrap_flag", sb_wrapped, 1);
    chk("wrap_waddr", sb_waddr, 6);
    sb_re = 1; sb_raddr = 0;
    step();
    chk("wrap_rd0", sb_rdata, 1024);
    sb_raddr = 5;
    step();
    chk("wrap_rd5", sb_rdata, 1029);
    sb_re = 0;
    do_reset();

    // freeze holds the write address
    out_re = 1;
    push_n(10, 32'h100);
    sb_freeze = 1;
    push_n(5, 32'h200);
    chk("frozen_waddr", sb_waddr, 10);
    sb_freeze = 0;
    push_n(1, 32'hF00D);
    chk("freeze_waddr", sb_waddr, 11);
    sb_re = 1; sb_raddr = 10;
    step();
    sb_re = 0;
    chk("freeze_rd10", sb_rdata, 32'hF00D);
    do_reset();

    // event metadata
    out_re = 1;
    push_n(3, 32'h300);
    i_eof = 1; step(); i_eof = 0;
    push_n(4, 32'h400);
    i_eof = 1; step(); i_eof = 0;
    sb_meta_re = 1; sb_meta_raddr = 0;
    step();
`ifdef LSF_SPY_META_EN
    chk("meta_cnt", sb_meta_count, 2);
    chk("meta0", sb_meta_rdata, 3);
`else
    chk("meta_cnt", sb_meta_count, 0);
    chk("meta0", sb_meta_rdata, 0);
`endif
    sb_meta_raddr = 1;
    step();
`ifdef LSF_SPY_META_EN
    chk("meta1", sb_meta_rdata, 7);
`else
    chk("meta1", sb_meta_rdata, 0);
`endif
    sb_meta_re = 0;
    do_reset();

    // randomized traffic: slow drain first, then fast drain
    for (int i = 0; i < 800; i++) begin
      int a;
      for (int c = 0; c < NCH; c++) begin
        in_we[c] = ($urandom_range(0, 3) == 0) ? 1'b1 : (!in_af[c] && $urandom_range(0, 1) == 1);
        in_data[c*DW +: DW] = $urandom;
      end
      out_re = (i < 400) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
      if ($urandom_range(0, 19) == 0) sb_freeze = ~sb_freeze;
      i_eof = ($urandom_range(0, 19) == 0);
      sb_re = 0;
      if ($urandom_range(0, 2) == 0 && (m_wrap || m_waddr > 0)) begin
        a = m_wrap ? $urandom_range(0, SPY-1) : $urandom_range(0, m_waddr-1);
        if (m_vld[a]) begin sb_re = 1; sb_raddr = SL'(a); end
      end
      sb_meta_re = 0;
`ifdef LSF_SPY_META_EN
      if (m_mcnt > 0 && $urandom_range(0, 4) == 0) begin
        sb_meta_re = 1; sb_meta_raddr = ML'($urandom_range(0, m_mcnt-1));
      end
`else
      sb_meta_re = $urandom_range(0, 1);
      sb_meta_raddr = ML'($urandom);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
